// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and constants for the PS/2 keyboard front end feeding the LM80C key matrix.
package ps2_keymatrix_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE_SKIP
    } dec_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // The Pause key sends E1 followed by seven more bytes that carry no key state.
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE};
    endfunction

    function automatic logic is_overrun(input logic [7:0] code);
        return code inside {8'h00, 8'hFF};
    endfunction

    function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.hit = 1'b1;
        p.row = row;
        p.col = col;
        return p;
    endfunction

endpackage

// File: rtl/ps2_key_lut.sv
// Scancode (with E0 extension flag) to LM80C matrix position table.
module ps2_key_lut
    import ps2_keymatrix_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_pos_t   pos
);

    always_comb begin
        pos = '0;
        case ({ext, code})
            9'h016: pos = key_at(3'd1, 3'd0);  // 1
            9'h01C: pos = key_at(3'd2, 3'd1);  // A
            9'h01B: pos = key_at(3'd3, 3'd1);  // S
            9'h023: pos = key_at(3'd3, 3'd2);  // D
            9'h012: pos = key_at(3'd4, 3'd0);  // left shift
            9'h014: pos = key_at(3'd5, 3'd0);  // ctrl
            9'h029: pos = key_at(3'd7, 3'd4);  // space
            9'h05A: pos = key_at(3'd0, 3'd7);  // return
            9'h066: pos = key_at(3'd0, 3'd0);  // backspace
            9'h175: pos = key_at(3'd6, 3'd0);  // up
            9'h172: pos = key_at(3'd6, 3'd1);  // down
            9'h16B: pos = key_at(3'd6, 3'd2);  // left
            9'h174: pos = key_at(3'd6, 3'd3);  // right
            default: pos = '0;
        endcase
    end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 frame receiver and make/break decoder maintaining the active-low 8x8 LM80C key matrix.
// state         | meaning
// ST_NORMAL     | waiting for a prefix or a plain scancode
// ST_EXT        | E0 seen, next code is an extended key
// ST_BRK        | F0 seen, next code is a release
// ST_EXT_BRK    | E0 F0 seen, next code is an extended release
// ST_PAUSE_SKIP | swallowing the remainder of the Pause sequence
module ps2_keymatrix
    import ps2_keymatrix_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int FILTER_LEN     = 4
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] KM [7:0],
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_filt;
    logic [FLT_W-1:0]       flt_cnt;
    logic                   ps2_fall;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_filt  <= 1'b1;
            flt_cnt   <= '0;
            ps2_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            ps2_fall  <= 1'b0;
            if (clk_s == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                flt_cnt  <= '0;
                ps2_fall <= ~clk_s;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    logic [3:0]       bit_cnt;
    logic [8:0]       shift;
    logic [TMO_W-1:0] tmo_cnt;
    logic             byte_rdy;
    logic [7:0]       rx_byte;

    // shift collects data LSB first plus parity in bit 8; bit_cnt 10 means the stop bit is next.
    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            bit_cnt   <= '0;
            shift     <= '0;
            tmo_cnt   <= '0;
            byte_rdy  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (ps2_fall) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
                if (bit_cnt == 4'd0) begin
                    if (!data_s) bit_cnt <= 4'd1;
                end else if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (data_s && (^shift)) begin
                        byte_rdy <= 1'b1;
                        rx_byte  <= shift[7:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift   <= {data_s, shift[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tmo_cnt == '0) begin
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
        end
    end

    dec_state_t state;
    logic [2:0] skip_cnt;
    key_pos_t   pos;
    logic       dec_ext;
    logic       dec_brk;

    assign dec_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign dec_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

    ps2_key_lut u_lut (
        .ext  (dec_ext),
        .code (rx_byte),
        .pos  (pos)
    );

    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            state       <= ST_NORMAL;
            skip_cnt    <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
        end else begin
            key_valid <= 1'b0;
            if (byte_rdy) begin
                if (state == ST_PAUSE_SKIP) begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= ST_NORMAL;
                end else if (is_overrun(rx_byte)) begin
                    for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
                    state <= ST_NORMAL;
                end else if (is_ignored(rx_byte)) begin
                    state <= state;
                end else if (rx_byte == PS2_PAUSE) begin
                    state    <= ST_PAUSE_SKIP;
                    skip_cnt <= PAUSE_SKIP_LEN;
                end else if (rx_byte == PS2_EXT) begin
                    if (state == ST_NORMAL) state <= ST_EXT;
                end else if (rx_byte == PS2_BRK) begin
                    if (state == ST_NORMAL) state <= ST_BRK;
                    else if (state == ST_EXT) state <= ST_EXT_BRK;
                end else begin
                    state <= ST_NORMAL;
                    if (pos.hit) begin
                        KM[pos.row][pos.col] <= dec_brk;
                        key_valid   <= 1'b1;
                        key_code    <= rx_byte;
                        key_ext     <= dec_ext;
                        key_release <= dec_brk;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: table-driven PS/2 frames with an event scoreboard.
`timescale 1ns/1ps
module tb_ps2_keymatrix;

    localparam int TIMEOUT_CYCLES = 16384;
    localparam logic [63:0] ALL_FF = {8{8'hFF}};

    logic       sys_clock = 1'b0;
    logic       RESET;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] KM [7:0];
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_keymatrix #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (4)
    ) dut (
        .sys_clock   (sys_clock),
        .RESET       (RESET),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .KM          (KM),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .frame_err   (frame_err)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        bit          err;
        logic [7:0]  code;
        bit          ext;
        bit          rel;
        logic [63:0] km;
    } exp_t;

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        bit          has_evt;
        bit          evt_err;
        bit          e_ext;
        bit          e_rel;
        logic [63:0] km;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic logic [63:0] km_flat();
        logic [63:0] f;
        for (int r = 0; r < 8; r++) f[r*8 +: 8] = KM[r];
        return f;
    endfunction

    function automatic logic [63:0] setrow(input logic [63:0] km, input int row, input logic [7:0] val);
        logic [63:0] k;
        k = km;
        k[row*8 +: 8] = val;
        return k;
    endfunction

    function automatic void add(input logic [7:0] code, input bit bad, input bit has, input bit err,
                                input bit ext, input bit rel, input logic [63:0] km);
        vec_t v;
        v.code = code; v.bad_par = bad; v.has_evt = has; v.evt_err = err;
        v.e_ext = ext; v.e_rel = rel; v.km = km;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Every key_valid / frame_err pulse must match the oldest expected event.
    always @(negedge sys_clock) begin
        exp_t e;
        bit   ok;
        if (!RESET && (key_valid || frame_err)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: key_valid=%0b frame_err=%0b key_code=%h km=%h, required no event",
                         key_valid, frame_err, key_code, km_flat());
            end else begin
                e = sb.pop_front();
                if (e.err)
                    ok = frame_err && !key_valid && (km_flat() == e.km);
                else
                    ok = key_valid && !frame_err && (key_code == e.code) && (key_ext == e.ext) &&
                         (key_release == e.rel) && (km_flat() == e.km);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL event: got kv=%0b fe=%0b code=%h ext=%0b rel=%0b km=%h, required err=%0b code=%h ext=%0b rel=%0b km=%h",
                             key_valid, frame_err, key_code, key_ext, key_release, km_flat(),
                             e.err, e.code, e.ext, e.rel, e.km);
                end
            end
        end
    end

    task automatic ps2_bit(input bit b);
        @(negedge sys_clock);
        ps2_data = b;
        repeat (10) @(negedge sys_clock);
        ps2_clk = 1'b0;
        repeat (20) @(negedge sys_clock);
        ps2_clk = 1'b1;
        repeat (10) @(negedge sys_clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    task automatic drain(input string name);
        repeat (40) @(negedge sys_clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d outstanding events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        vec_t v;
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            v = vecs[i];
            if (v.has_evt) begin
                e.err = v.evt_err; e.code = v.code; e.ext = v.e_ext; e.rel = v.e_rel; e.km = v.km;
                sb.push_back(e);
            end
            send_frame(v.code, v.bad_par, 11);
            drain($sformatf("vec%0d", i));
            check($sformatf("km_vec%0d", i), km_flat(), v.km);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] km_a, km_up, km_sp, km_sa, km_ret;
        exp_t        e;

        km_a   = setrow(ALL_FF, 2, 8'hFD);
        km_up  = setrow(ALL_FF, 6, 8'hFE);
        km_sp  = setrow(ALL_FF, 7, 8'hEF);
        km_sa  = setrow(km_sp, 2, 8'hFD);
        km_ret = setrow(ALL_FF, 0, 8'h7F);

        // code, bad parity, event, error event, ext, release, KM afterwards
        add(8'h1C, 0, 1, 0, 0, 0, km_a);     // 0  A make
        add(8'hF0, 0, 0, 0, 0, 0, km_a);     // 1
        add(8'h1C, 0, 1, 0, 0, 1, ALL_FF);   // 2  A break
        add(8'hE0, 0, 0, 0, 0, 0, ALL_FF);   // 3
        add(8'h75, 0, 1, 0, 1, 0, km_up);    // 4  up make
        add(8'hE0, 0, 0, 0, 0, 0, km_up);    // 5
        add(8'hF0, 0, 0, 0, 0, 0, km_up);    // 6
        add(8'h75, 0, 1, 0, 1, 1, ALL_FF);   // 7  up break
        add(8'h1C, 1, 1, 1, 0, 0, ALL_FF);   // 8  parity error
        add(8'h29, 0, 1, 0, 0, 0, km_sp);    // 9  space make after timeout
        add(8'hAA, 0, 0, 0, 0, 0, km_sp);    // 10 ignored
        add(8'h7E, 0, 0, 0, 0, 0, km_sp);    // 11 unmapped
        add(8'h1C, 0, 1, 0, 0, 0, km_sa);    // 12
        add(8'h1C, 0, 1, 0, 0, 0, km_sa);    // 13 auto-repeat
        add(8'hFF, 0, 0, 0, 0, 0, ALL_FF);   // 14 overrun
        add(8'hE1, 0, 0, 0, 0, 0, ALL_FF);   // 15..22 pause sequence
        add(8'h14, 0, 0, 0, 0, 0, ALL_FF);
        add(8'h77, 0, 0, 0, 0, 0, ALL_FF);
        add(8'hE1, 0, 0, 0, 0, 0, ALL_FF);
        add(8'hF0, 0, 0, 0, 0, 0, ALL_FF);
        add(8'h14, 0, 0, 0, 0, 0, ALL_FF);
        add(8'hF0, 0, 0, 0, 0, 0, ALL_FF);
        add(8'h77, 0, 0, 0, 0, 0, ALL_FF);
        add(8'h29, 0, 1, 0, 0, 0, km_sp);    // 23 plain make, decoder back in NORMAL
        add(8'h5A, 0, 1, 0, 0, 0, km_ret);   // 24 return after async reset

        RESET    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge sys_clock);
        RESET = 1'b0;
        repeat (5) @(negedge sys_clock);
        check("reset_km", km_flat(), ALL_FF);
        check("reset_outputs", 64'({key_valid, key_code, key_ext, key_release, frame_err}), 64'd0);

        run_vectors(0, 8);

        // Partial frame followed by a long idle clock must be discarded with an error.
        e.err = 1'b1; e.code = '0; e.ext = 1'b0; e.rel = 1'b0; e.km = ALL_FF;
        sb.push_back(e);
        send_frame(8'h29, 0, 5);
        repeat (TIMEOUT_CYCLES + 100) @(negedge sys_clock);
        drain("timeout");
        check("km_timeout", km_flat(), ALL_FF);

        run_vectors(9, 23);

        // Reset arriving between clock edges in the middle of a frame.
        send_frame(8'h5A, 0, 5);
        @(negedge sys_clock);
        #2 RESET = 1'b1;
        #1;
        check("km_async_reset", km_flat(), ALL_FF);
        check("outputs_async_reset", 64'({key_valid, key_code, key_ext, key_release, frame_err}), 64'd0);
        repeat (3) @(negedge sys_clock);
        RESET    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge sys_clock);

        run_vectors(24, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
